// File: rtl/iact_sched_pkg.sv
// iact_sched_pkg: shared types, defaults and round-robin pointer helper for the iact scheduler
package iact_sched_pkg;
  localparam int I_COUNT_DEF = 3;
  localparam int BURST_W_DEF = 8;
  localparam int TMO_W_DEF = 4;
  localparam int SEL_W_DEF = $clog2(I_COUNT_DEF);
  typedef enum logic {IDLE, GRANT} state_t;
  typedef logic [SEL_W_DEF-1:0] sel_t;
  function automatic int next_rr(input int ptr, input int n = I_COUNT_DEF);
    return (ptr + 1 >= n) ? 0 : ptr + 1;
  endfunction
endpackage

// File: rtl/iact_mux_scheduler_rr_arbiter.sv
// rr_arbiter: combinational round-robin pick, first set request scanning upward from ptr with wrap
module rr_arbiter #(
  parameter int N = 3,
  parameter int SW = 2
) (
  input  logic [N-1:0]  req,
  input  logic [SW-1:0] ptr,
  output logic [SW-1:0] winner,
  output logic          any
);
  // scan offsets from farthest to nearest so the closest requester to ptr wins
  always_comb begin
    winner = '0;
    any = |req;
    for (int i = N - 1; i >= 0; i--)
      if (req[(int'(ptr) + i) % N]) winner = SW'((int'(ptr) + i) % N);
  end
endmodule

// File: rtl/iact_mux_scheduler.sv
// iact_mux_scheduler: round-robin burst scheduler driving the iact mux select (optional stall timeout: IACT_SCHED_TIMEOUT_EN)
module iact_mux_scheduler
  import iact_sched_pkg::*;
#(
  parameter int I_COUNT = I_COUNT_DEF,
  parameter int BURST_W = BURST_W_DEF,
  parameter int TMO_W = TMO_W_DEF,
  localparam int SEL_W = $clog2(I_COUNT)
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               enable_i,
  input  logic [BURST_W-1:0] burst_len_i,
  input  logic [I_COUNT-1:0] valid_i,
  input  logic               ready_i,
  output logic [SEL_W-1:0]   sel_o,
  output logic               sel_valid_o,
  output logic [BURST_W-1:0] beat_cnt_o,
  output logic               burst_done_o
);
  state_t state_q, state_d;
  logic [SEL_W-1:0] sel_q, sel_d, rr_ptr_q, rr_ptr_d, arb_ptr, win, nxt;
  logic [BURST_W-1:0] len_q, len_d, cnt_q, cnt_d, len_eff;
  logic done_q, done_d, beat, last, end_burst, any;
`ifdef IACT_SCHED_TIMEOUT_EN
  logic [TMO_W-1:0] tmo_q, tmo_d;
  logic tmo_end;
  assign tmo_end = (state_q == GRANT) && !valid_i[sel_q] && (tmo_q == TMO_W'((1 << TMO_W) - 2));
`endif
  assign beat = (state_q == GRANT) && valid_i[sel_q] && ready_i;
  assign last = beat && (cnt_q + 1'b1 == len_q);
`ifdef IACT_SCHED_TIMEOUT_EN
  assign end_burst = last || tmo_end;
`else
  assign end_burst = last;
`endif
  assign nxt = SEL_W'(next_rr(int'(sel_q), I_COUNT));
  assign arb_ptr = end_burst ? nxt : rr_ptr_q;
  assign len_eff = (burst_len_i == '0) ? BURST_W'(1) : burst_len_i;
  rr_arbiter #(.N(I_COUNT), .SW(SEL_W)) u_arb (
    .req(valid_i),
    .ptr(arb_ptr),
    .winner(win),
    .any(any)
  );
  // state, grant and counters register
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      sel_q <= '0;
      rr_ptr_q <= '0;
      len_q <= BURST_W'(1);
      cnt_q <= '0;
      done_q <= 1'b0;
`ifdef IACT_SCHED_TIMEOUT_EN
      tmo_q <= '0;
`endif
    end else begin
      state_q <= state_d;
      sel_q <= sel_d;
      rr_ptr_q <= rr_ptr_d;
      len_q <= len_d;
      cnt_q <= cnt_d;
      done_q <= done_d;
`ifdef IACT_SCHED_TIMEOUT_EN
      tmo_q <= tmo_d;
`endif
    end
  end
  // next-state: grant on request, count beats, re-arbitrate back-to-back at burst end
  always_comb begin
    state_d = state_q;
    sel_d = sel_q;
    rr_ptr_d = rr_ptr_q;
    len_d = len_q;
    cnt_d = cnt_q;
    done_d = 1'b0;
`ifdef IACT_SCHED_TIMEOUT_EN
    tmo_d = (state_q == GRANT && !valid_i[sel_q]) ? tmo_q + 1'b1 : '0;
`endif
    if (state_q == IDLE) begin
      if (enable_i && any) begin
        state_d = GRANT;
        sel_d = win;
        len_d = len_eff;
        cnt_d = '0;
`ifdef IACT_SCHED_TIMEOUT_EN
        tmo_d = '0;
`endif
      end
    end else begin
      if (beat) cnt_d = cnt_q + 1'b1;
      if (end_burst) begin
        rr_ptr_d = nxt;
        done_d = 1'b1;
`ifdef IACT_SCHED_TIMEOUT_EN
        tmo_d = '0;
`endif
        if (enable_i && any) begin
          sel_d = win;
          len_d = len_eff;
          cnt_d = '0;
        end else begin
          state_d = IDLE;
        end
      end
    end
  end
  assign sel_o = sel_q;
  assign sel_valid_o = (state_q == GRANT);
  assign beat_cnt_o = cnt_q;
  assign burst_done_o = done_q;
endmodule

// File: tb/tb_iact_mux_scheduler.sv
// tb_iact_mux_scheduler: table-driven and directed checks of the iact round-robin burst scheduler
module tb_iact_mux_scheduler;
  logic clk = 0, rst_n = 0, en = 0, rdy = 0;
  logic [7:0] len = 0;
  logic [2:0] valid = 0;
  logic [1:0] sel;
  logic sv, done;
  logic [7:0] cnt;
  int checks = 0, errors = 0;

  typedef struct {
    bit rst; bit e; logic [2:0] v; bit r; logic [7:0] l;
    logic [1:0] sel; bit sv; logic [7:0] cnt; bit done;
  } vec_t;
  vec_t tbl[$];

  iact_mux_scheduler dut (
    .clk_i(clk), .rst_ni(rst_n), .enable_i(en), .burst_len_i(len),
    .valid_i(valid), .ready_i(rdy), .sel_o(sel), .sel_valid_o(sv),
    .beat_cnt_o(cnt), .burst_done_o(done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 0; en = 0; valid = 0; rdy = 0; len = 0;
    step();
    step();
    rst_n = 1;
  endtask

  task automatic chk_all(input string tag, input int s, input int v, input int c, input int d);
    chk({tag, ".sel"}, sel, s);
    chk({tag, ".sel_valid"}, sv, v);
    chk({tag, ".beat_cnt"}, cnt, c);
    chk({tag, ".done"}, done, d);
  endtask

  initial begin
    // reset with all sources requesting
    rst_n = 0; en = 1; valid = 3'b111; rdy = 1;
    #1;
    chk_all("reset", 0, 0, 0, 0);
    // round-robin, len 2, no bubbles
    tbl.push_back('{1, 1, 3'b111, 1, 8'd2, 2'd0, 1, 8'd0, 0});
    tbl.push_back('{0, 1, 3'b111, 1, 8'd2, 2'd0, 1, 8'd1, 0});
    tbl.push_back('{0, 1, 3'b111, 1, 8'd2, 2'd1, 1, 8'd0, 1});
    tbl.push_back('{0, 1, 3'b111, 1, 8'd2, 2'd1, 1, 8'd1, 0});
    tbl.push_back('{0, 1, 3'b111, 1, 8'd2, 2'd2, 1, 8'd0, 1});
    tbl.push_back('{0, 1, 3'b111, 1, 8'd2, 2'd2, 1, 8'd1, 0});
    tbl.push_back('{0, 1, 3'b111, 1, 8'd2, 2'd0, 1, 8'd0, 1});
    tbl.push_back('{0, 1, 3'b111, 1, 8'd2, 2'd0, 1, 8'd1, 0});
    // sparse: only source 2, length 0 treated as 1
    tbl.push_back('{1, 1, 3'b100, 1, 8'd0, 2'd2, 1, 8'd0, 0});
    tbl.push_back('{0, 1, 3'b100, 1, 8'd0, 2'd2, 1, 8'd0, 1});
    tbl.push_back('{0, 1, 3'b100, 1, 8'd0, 2'd2, 1, 8'd0, 1});
    // current source is lowest priority: src 0 and 1 requesting, len 1
    tbl.push_back('{1, 1, 3'b011, 1, 8'd1, 2'd0, 1, 8'd0, 0});
    tbl.push_back('{0, 1, 3'b011, 1, 8'd1, 2'd1, 1, 8'd0, 1});
    tbl.push_back('{0, 1, 3'b011, 1, 8'd1, 2'd0, 1, 8'd0, 1});
    // enable low: no grant
    tbl.push_back('{1, 0, 3'b111, 1, 8'd2, 2'd0, 0, 8'd0, 0});
    foreach (tbl[i]) begin
      if (tbl[i].rst) do_reset();
      en = tbl[i].e; valid = tbl[i].v; rdy = tbl[i].r; len = tbl[i].l;
      step();
      chk_all($sformatf("vec%0d", i), tbl[i].sel, tbl[i].sv, tbl[i].cnt, tbl[i].done);
    end

    // backpressure with len 4, burst_len change mid-burst ignored
    do_reset();
    en = 1; valid = 3'b111; rdy = 1; len = 4;
    step();
    len = 1;
    step();
    step();
    chk_all("bp_pre", 0, 1, 2, 0);
    rdy = 0;
    for (int k = 0; k < 5; k++) begin
      step();
      chk_all($sformatf("bp_stall%0d", k), 0, 1, 2, 0);
    end
    rdy = 1;
    step();
    chk_all("bp_beat3", 0, 1, 3, 0);
    step();
    chk_all("bp_end", 1, 1, 0, 1);
    // asynchronous reset mid-burst
    step();
    #2;
    rst_n = 0;
    #1;
    chk_all("async_rst", 0, 0, 0, 0);

    // drain: enable drops after first beat of a len-3 burst
    do_reset();
    en = 1; valid = 3'b111; rdy = 1; len = 3;
    step();
    step();
    chk_all("drain_b1", 0, 1, 1, 0);
    en = 0;
    step();
    chk_all("drain_b2", 0, 1, 2, 0);
    step();
    chk_all("drain_b3", 0, 0, 3, 1);
    step();
    chk_all("drain_idle", 0, 0, 3, 0);
    step();
    chk_all("drain_idle2", 0, 0, 3, 0);

    // granted source drops valid
    do_reset();
    en = 1; valid = 3'b111; rdy = 1; len = 4;
    step();
    valid = 3'b110;
`ifdef IACT_SCHED_TIMEOUT_EN
    for (int k = 0; k < 14; k++) begin
      step();
      chk_all($sformatf("tmo_wait%0d", k), 0, 1, 0, 0);
    end
    step();
    chk_all("tmo_release", 1, 1, 0, 1);
`else
    for (int k = 0; k < 20; k++) begin
      step();
      chk_all($sformatf("hold%0d", k), 0, 1, 0, 0);
    end
`endif
    valid = 3'b111;
    step();
`ifdef IACT_SCHED_TIMEOUT_EN
    chk_all("after_tmo", 1, 1, 1, 0);
`else
    chk_all("hold_resume", 0, 1, 1, 0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
